// File: rtl/alu_sequencer.sv
// Multi-cycle ALU command sequencer: issues an opcode to an external registered ALU
// N times, feeding each result back as operand A. Optional macro ALU_SEQ_ZERO_FLAG_EN adds rsp_zero_o.
module alu_sequencer #(
    parameter int          ITER_W      = 4,
    parameter logic [4:0]  IDLE_OPCODE = 5'b00011
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [4:0]        cmd_opcode_i,
    input  logic [31:0]       cmd_a_i,
    input  logic [31:0]       cmd_b_i,
    input  logic [ITER_W-1:0] cmd_count_i,
    output logic [4:0]        alu_opcode_o,
    output logic [31:0]       alu_a_o,
    output logic [31:0]       alu_b_o,
    input  logic [31:0]       alu_result_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_data_o,
`ifdef ALU_SEQ_ZERO_FLAG_EN
    output logic              rsp_zero_o,
`endif
    output logic              busy_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    localparam logic [ITER_W-1:0] CNT_ONE = {{(ITER_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [4:0]        op_q, op_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [ITER_W-1:0] cnt_q, cnt_d;
    logic [31:0]       data_q, data_d;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic              zero_q, zero_d;
`endif

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            zero_q  <= zero_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
`ifdef ALU_SEQ_ZERO_FLAG_EN
        zero_d  = zero_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    op_d    = cmd_opcode_i;
                    a_d     = cmd_a_i;
                    b_d     = cmd_b_i;
                    cnt_d   = (cmd_count_i == '0) ? CNT_ONE : cmd_count_i;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                // The ALU result registered from the ISSUE cycle is valid here.
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q != CNT_ONE) begin
                    a_d     = alu_result_i;
                    state_d = S_ISSUE;
                end else begin
                    data_d  = alu_result_i;
`ifdef ALU_SEQ_ZERO_FLAG_EN
                    zero_d  = (alu_result_i == 32'd0);
`endif
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operand outputs come straight from the latched registers, which only
    // change on the edge entering ISSUE, so they hold their values elsewhere.
    assign alu_opcode_o = (state_q == S_ISSUE) ? op_q : IDLE_OPCODE;
    assign alu_a_o      = a_q;
    assign alu_b_o      = b_q;
    assign cmd_ready_o  = (state_q == S_IDLE);
    assign rsp_valid_o  = (state_q == S_RESP);
    assign rsp_data_o   = data_q;
    assign busy_o       = (state_q != S_IDLE);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    assign rsp_zero_o   = zero_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a registered ALU model, a transaction-level
// reference model checked every negedge, and directed vectors with literal expectations.
module tb_alu_sequencer;

    localparam int         ITER_W  = 4;
    localparam logic [4:0] IDLE_OP = 5'b00011;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_INC  = 3'b010;
    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LEFT = 2'b01;
    localparam logic [1:0] SH_RGHT = 2'b10;

    logic              clock_i = 1'b0;
    logic              reset_i = 1'b0;
    logic              cmd_valid_i = 1'b0;
    logic              cmd_ready_o;
    logic [4:0]        cmd_opcode_i = '0;
    logic [31:0]       cmd_a_i = '0;
    logic [31:0]       cmd_b_i = '0;
    logic [ITER_W-1:0] cmd_count_i = '0;
    logic [4:0]        alu_opcode_o;
    logic [31:0]       alu_a_o;
    logic [31:0]       alu_b_o;
    logic [31:0]       alu_result_i = '0;
    logic              rsp_valid_o;
    logic              rsp_ready_i = 1'b0;
    logic [31:0]       rsp_data_o;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic              rsp_zero_o;
`endif
    logic              busy_o;

    int total = 0;
    int bad   = 0;

    alu_sequencer #(.ITER_W(ITER_W), .IDLE_OPCODE(IDLE_OP)) dut (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_opcode_i (cmd_opcode_i),
        .cmd_a_i      (cmd_a_i),
        .cmd_b_i      (cmd_b_i),
        .cmd_count_i  (cmd_count_i),
        .alu_opcode_o (alu_opcode_o),
        .alu_a_o      (alu_a_o),
        .alu_b_o      (alu_b_o),
        .alu_result_i (alu_result_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_data_o   (rsp_data_o),
`ifdef ALU_SEQ_ZERO_FLAG_EN
        .rsp_zero_o   (rsp_zero_o),
`endif
        .busy_o       (busy_o)
    );

    initial forever #5 clock_i = ~clock_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behaviour of the external ALU: operation first, then shift by one.
    function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] r;
        case (op[4:2])
            OP_ADD:  r = a + b;
            OP_INC:  r = a + 32'd1;
            default: r = 32'd0;
        endcase
        case (op[1:0])
            SH_LEFT: r = r << 1;
            SH_RGHT: r = r >> 1;
            default: r = r;
        endcase
        return r;
    endfunction

    initial forever begin
        @(posedge clock_i);
        alu_result_i <= alu_fn(alu_opcode_o, alu_a_o, alu_b_o);
    end

    // Reference model: precomputes the chain of results at accept time and
    // times the response purely by counting edges (2 per iteration).
    bit          m_busy = 0;
    bit          m_valid = 0;
    bit          m_zero = 0;
    int          m_t = 0;
    int          m_n = 0;
    logic [4:0]  m_op = '0;
    logic [31:0] m_b = '0;
    logic [31:0] m_data = '0;
    logic [31:0] m_vals [0:16];

    initial forever begin
        @(posedge clock_i or posedge reset_i);
        if (reset_i) begin
            m_busy = 0; m_valid = 0; m_zero = 0; m_t = 0; m_n = 0;
            m_op = '0; m_b = '0; m_data = '0;
        end else if (!m_busy) begin
            if (cmd_valid_i) begin
                m_op = cmd_opcode_i;
                m_b = cmd_b_i;
                m_n = (cmd_count_i == 0) ? 1 : int'(cmd_count_i);
                m_vals[0] = cmd_a_i;
                for (int j = 0; j < m_n; j++) m_vals[j+1] = alu_fn(m_op, m_vals[j], m_b);
                m_busy = 1;
                m_t = 0;
            end
        end else if (!m_valid) begin
            m_t++;
            if (m_t == 2 * m_n) begin
                m_valid = 1;
                m_data = m_vals[m_n];
                m_zero = (m_data == 32'd0);
            end
        end else if (rsp_ready_i) begin
            m_valid = 0;
            m_busy = 0;
        end
    end

    initial forever begin
        @(negedge clock_i);
        chk("cmd_ready", {31'd0, cmd_ready_o}, {31'd0, !m_busy});
        chk("busy", {31'd0, busy_o}, {31'd0, m_busy});
        chk("rsp_valid", {31'd0, rsp_valid_o}, {31'd0, m_valid});
        chk("rsp_data", rsp_data_o, m_data);
`ifdef ALU_SEQ_ZERO_FLAG_EN
        chk("rsp_zero", {31'd0, rsp_zero_o}, {31'd0, m_zero});
`endif
        if (m_busy && !m_valid && (m_t % 2 == 0)) begin
            chk("issue_op", {27'd0, alu_opcode_o}, {27'd0, m_op});
            chk("issue_a", alu_a_o, m_vals[m_t/2]);
            chk("issue_b", alu_b_o, m_b);
        end else begin
            chk("idle_op", {27'd0, alu_opcode_o}, {27'd0, IDLE_OP});
        end
    end

    logic [31:0] seen_a [$];

    task automatic run_cmd(input bit rel_rst, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [ITER_W-1:0] cnt,
                           output int lat, output logic [31:0] data);
        @(negedge clock_i);
        if (rel_rst) reset_i = 1'b0;
        cmd_valid_i = 1'b1; cmd_opcode_i = op; cmd_a_i = a; cmd_b_i = b; cmd_count_i = cnt;
        seen_a.delete();
        @(posedge clock_i); #1;
        cmd_valid_i = 1'b0;
        for (lat = 1; lat <= 100; lat++) begin
            if (alu_opcode_o != IDLE_OP) seen_a.push_back(alu_a_o);
            @(posedge clock_i); #1;
            if (rsp_valid_o) break;
        end
        data = rsp_data_o;
        $display("cmd op=%b a=%h b=%h cnt=%0d -> data=%h latency=%0d", op, a, b, cnt, data, lat);
    endtask

    task automatic finish_rsp(input string name);
        @(negedge clock_i);
        rsp_ready_i = 1'b1;
        @(posedge clock_i); #1;
        chk({name, "_release_valid"}, {31'd0, rsp_valid_o}, 32'd0);
        chk({name, "_release_ready"}, {31'd0, cmd_ready_o}, 32'd1);
        rsp_ready_i = 1'b0;
    endtask

    int          lat;
    logic [31:0] data;

    initial begin
        // Asynchronous reset with no clock edge yet
        #1 reset_i = 1'b1;
        #1;
        chk("rst_ready", {31'd0, cmd_ready_o}, 32'd1);
        chk("rst_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_op", {27'd0, alu_opcode_o}, 32'd3);
        chk("rst_a", alu_a_o, 32'd0);
        chk("rst_b", alu_b_o, 32'd0);
        chk("rst_data", rsp_data_o, 32'd0);
        repeat (2) @(negedge clock_i);

        // Single add, accepted on the first edge after reset release
        run_cmd(1'b1, {OP_ADD, SH_NONE}, 32'd7, 32'd5, 4'd1, lat, data);
        chk("add_latency", lat, 2);
        chk("add_data", data, 32'd12);
`ifdef ALU_SEQ_ZERO_FLAG_EN
        chk("add_zero", {31'd0, rsp_zero_o}, 32'd0);
`endif
        // Backpressure with a competing command offered
        for (int i = 0; i < 5; i++) begin
            @(negedge clock_i);
            cmd_valid_i = 1'b1; cmd_opcode_i = {OP_ADD, SH_NONE};
            cmd_a_i = 32'd99; cmd_b_i = 32'd1; cmd_count_i = 4'd1;
            @(posedge clock_i); #1;
            chk("bp_valid", {31'd0, rsp_valid_o}, 32'd1);
            chk("bp_data", rsp_data_o, 32'd12);
            chk("bp_ready", {31'd0, cmd_ready_o}, 32'd0);
        end
        cmd_valid_i = 1'b0;
        finish_rsp("bp");
        @(posedge clock_i); #1;
        chk("bp_not_queued", {31'd0, busy_o}, 32'd0);

        // Three increments
        run_cmd(1'b0, {OP_INC, SH_NONE}, 32'd5, 32'd0, 4'd3, lat, data);
        chk("inc_latency", lat, 6);
        chk("inc_data", data, 32'd8);
        chk("inc_issue_count", seen_a.size(), 3);
        if (seen_a.size() == 3) begin
            chk("inc_a0", seen_a[0], 32'd5);
            chk("inc_a1", seen_a[1], 32'd6);
            chk("inc_a2", seen_a[2], 32'd7);
        end
        finish_rsp("inc");

        // Increment + shift wrap, with rsp_ready held high beforehand
        rsp_ready_i = 1'b1;
        run_cmd(1'b0, {OP_INC, SH_LEFT}, 32'hFFFF_FFFF, 32'd0, 4'd1, lat, data);
        chk("wrap_latency", lat, 2);
        chk("wrap_data", data, 32'd0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
        chk("wrap_zero", {31'd0, rsp_zero_o}, 32'd1);
`endif
        @(posedge clock_i); #1;
        chk("wrap_consumed", {31'd0, rsp_valid_o}, 32'd0);
        rsp_ready_i = 1'b0;

        // Count of zero acts as one
        run_cmd(1'b0, {OP_ADD, SH_NONE}, 32'd100, 32'd23, 4'd0, lat, data);
        chk("cnt0_latency", lat, 2);
        chk("cnt0_data", data, 32'd123);
        finish_rsp("cnt0");

        // Reset during WAIT of a count=4 command
        @(negedge clock_i);
        cmd_valid_i = 1'b1; cmd_opcode_i = {OP_INC, SH_NONE};
        cmd_a_i = 32'd1; cmd_b_i = 32'd0; cmd_count_i = 4'd4;
        @(posedge clock_i); #1;
        cmd_valid_i = 1'b0;
        repeat (3) @(posedge clock_i);
        #2 reset_i = 1'b1;
        #1;
        chk("midrst_ready", {31'd0, cmd_ready_o}, 32'd1);
        chk("midrst_busy", {31'd0, busy_o}, 32'd0);
        chk("midrst_op", {27'd0, alu_opcode_o}, 32'd3);
        chk("midrst_a", alu_a_o, 32'd0);
        chk("midrst_data", rsp_data_o, 32'd0);
        $display("reset asserted during WAIT");
        repeat (2) @(negedge clock_i);
        reset_i = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock_i); #1;
            chk("midrst_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
        end
        run_cmd(1'b0, {OP_INC, SH_NONE}, 32'd10, 32'd0, 4'd2, lat, data);
        chk("post_rst_latency", lat, 4);
        chk("post_rst_data", data, 32'd12);
        finish_rsp("post_rst");

        repeat (2) @(negedge clock_i);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: ITER_W, 4, width of the iteration-count field.
REQ-002 Parameter: IDLE_OPCODE, 5'b00011, opcode driven to the ALU when no command is active (no operation, zeros output).
REQ-003 clock_i  input  1  sole clock; all state updates on posedge.
REQ-004 reset_i  input  1  reset, asynchronous, active-high.
REQ-005 cmd_valid_i  input  1  command offered.
REQ-006 cmd_ready_o  output  1  command accepted when cmd_valid_i and cmd_ready_o are both high at a posedge.
REQ-007 cmd_opcode_i  input  5  ALU opcode: [4:2] operation, [1:0] shift.
REQ-008 cmd_a_i, cmd_b_i  input  32 each  initial operands A and B.
REQ-009 cmd_count_i  input  ITER_W  number of iterations.
REQ-010 alu_opcode_o  output  5  opcode to ALU.
REQ-011 alu_a_o, alu_b_o  output  32 each  operands to ALU.
REQ-012 alu_result_i  input  32  registered ALU output, valid one cycle after the operands are presented.
REQ-013 rsp_valid_o  output  1  result available.
REQ-014 rsp_ready_i  input  1  consumer accepts result on posedge when rsp_valid_o is high.
REQ-015 rsp_data_o  output  32  final result.
REQ-016 busy_o  output  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP.
REQ-018 cmd_ready_o SHALL be high only in IDLE.
REQ-019 IDLE: on a handshake, latch opcode, A, B and count (count 0 treated as 1), then go to ISSUE.
REQ-020 ISSUE: drive alu_opcode_o, alu_a_o and alu_b_o from the latched registers, then go to WAIT.
REQ-021 WAIT: capture alu_result_i and decrement the remaining count.
  - If the remaining count is nonzero, load A with the captured result and go to ISSUE.
  - Otherwise, load rsp_data_o and go to RESP.
REQ-022 RESP: hold rsp_valid_o high with rsp_data_o stable until rsp_ready_i is high at a posedge, then go to IDLE.
REQ-023 cmd_ready_o SHALL remain low for the whole RESP state; there is no overlap of command and response.
REQ-024 Outside ISSUE, alu_opcode_o SHALL equal IDLE_OPCODE, and alu_a_o and alu_b_o SHALL hold their last values.
REQ-025 Latency: rsp_valid_o SHALL rise exactly 2N clock edges after the accept edge, where N is the effective count (1..2^ITER_W-1).
REQ-026 rsp_ready_i asserted before rsp_valid_o SHALL have no effect.
REQ-027 B SHALL remain constant across all iterations.
REQ-028 All arithmetic is performed in the ALU; the sequencer SHALL not modify data (32-bit wrap is the ALU's behaviour).
REQ-029 cmd_valid_i asserted outside IDLE SHALL be ignored and not queued.

Reset
REQ-030 While reset_i is high, the FSM SHALL be in IDLE, and all internal registers and rsp_data_o SHALL be 0.
REQ-031 Output values during reset: cmd_ready_o=1, rsp_valid_o=0, busy_o=0, alu_opcode_o=IDLE_OPCODE, alu_a_o=alu_b_o=0.
REQ-032 Reset asserted mid-command SHALL discard the command and any pending response.
REQ-033 After reset release, the first posedge SHALL be able to accept a command.

Configuration
REQ-034 Macro ALU_SEQ_ZERO_FLAG_EN:
  - When defined, add output rsp_zero_o (1 bit), registered together with rsp_data_o, high when rsp_data_o==0, reset 0.
  - When undefined, the port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-035 Reset: assert reset_i asynchronously mid-cycle -> outputs take REQ-031 values immediately; release -> cmd_ready_o=1.
REQ-036 Single add: opcode `ALU_ADD with `ALU_NO_SHIFT, A=7, B=5, count=1 -> rsp_data_o=12 with rsp_valid_o 2 edges after accept; zero flag (if enabled) =0.
REQ-037 Iteration: `ALU_INCREMENT with no shift, A=5, count=3 -> rsp_data_o=8 after 6 edges; alu_a_o observed as 5, 6, 7 in successive ISSUE cycles.
REQ-038 Shift plus wrap: `ALU_INCREMENT with `ALU_LEFT_SHIFT, A=32'hFFFFFFFF, count=1 -> rsp_data_o=0; rsp_zero_o=1 if enabled.
REQ-039 Backpressure: hold rsp_ready_i low 5 cycles -> rsp_valid_o and rsp_data_o stable, cmd_ready_o=0, and a new cmd_valid_i is ignored; raise rsp_ready_i -> IDLE next edge.
REQ-040 Edge cases: count=0 behaves as count=1; reset during WAIT of a count=4 command -> no rsp_valid_o, and the next command completes correctly.
